// File: rtl/ex_alu_div_if.sv
// ex_alu_div_if: ID/EX operands in, EX/MEM results out, stall/HI-LO.
// master = pipeline side, slave = ex_alu_div. ov_o only with EX_OVERFLOW_TRAP_EN.
interface ex_alu_div_if #(
   parameter int DATA_W    = 32,
   parameter int ALUOP_W   = 8,
   parameter int ALUSEL_W  = 3,
   parameter int REGADDR_W = 5
);
   logic                 flush_i;
   logic [ALUOP_W-1:0]   aluop_i;
   logic [ALUSEL_W-1:0]  alusel_i;
   logic [DATA_W-1:0]    reg1_i;
   logic [DATA_W-1:0]    reg2_i;
   logic [REGADDR_W-1:0] wd_i;
   logic                 wreg_i;
   logic [REGADDR_W-1:0] wd_o;
   logic                 wreg_o;
   logic [DATA_W-1:0]    wdata_o;
   logic                 whilo_o;
   logic [DATA_W-1:0]    hi_o;
   logic [DATA_W-1:0]    lo_o;
   logic                 stallreq_o;
`ifdef EX_OVERFLOW_TRAP_EN
   logic                 ov_o;
`endif

   modport master (
      output flush_i, aluop_i, alusel_i,
      output reg1_i, reg2_i, wd_i, wreg_i,
      input  wd_o, wreg_o, wdata_o, whilo_o,
      input  hi_o, lo_o, stallreq_o
`ifdef EX_OVERFLOW_TRAP_EN
      , input ov_o
`endif
   );

   modport slave (
      input  flush_i, aluop_i, alusel_i,
      input  reg1_i, reg2_i, wd_i, wreg_i,
      output wd_o, wreg_o, wdata_o, whilo_o,
      output hi_o, lo_o, stallreq_o
`ifdef EX_OVERFLOW_TRAP_EN
      , output ov_o
`endif
   );
endinterface

// File: rtl/ex_alu_div.sv
// ex_alu_div: MIPS32 execute stage; 1-cycle logic/shift/arith, 33-cycle DIV/DIVU.
// Ports: clk, rst (sync, active-high), bus (ex_alu_div_if.slave).
// Optional: EX_OVERFLOW_TRAP_EN adds signed ADD/SUB and ov_o.
module ex_alu_div #(
   parameter int DATA_W    = 32,
   parameter int ALUOP_W   = 8,
   parameter int ALUSEL_W  = 3,
   parameter int REGADDR_W = 5
) (
   input  logic         clk,
   input  logic         rst,
   ex_alu_div_if.slave  bus
);
   localparam int CNT_W = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam int M = DATA_W - 1;

   localparam logic [ALUSEL_W-1:0] SEL_LOGIC = ALUSEL_W'(3'b001);
   localparam logic [ALUSEL_W-1:0] SEL_SHIFT = ALUSEL_W'(3'b010);
   localparam logic [ALUSEL_W-1:0] SEL_ARITH = ALUSEL_W'(3'b100);

   localparam logic [ALUOP_W-1:0] OP_AND  = ALUOP_W'(8'h24);
   localparam logic [ALUOP_W-1:0] OP_OR   = ALUOP_W'(8'h25);
   localparam logic [ALUOP_W-1:0] OP_XOR  = ALUOP_W'(8'h26);
   localparam logic [ALUOP_W-1:0] OP_NOR  = ALUOP_W'(8'h27);
   localparam logic [ALUOP_W-1:0] OP_SLL  = ALUOP_W'(8'h7C);
   localparam logic [ALUOP_W-1:0] OP_SRL  = ALUOP_W'(8'h02);
   localparam logic [ALUOP_W-1:0] OP_SRA  = ALUOP_W'(8'h03);
   localparam logic [ALUOP_W-1:0] OP_ADDU = ALUOP_W'(8'h21);
   localparam logic [ALUOP_W-1:0] OP_SUBU = ALUOP_W'(8'h23);
   localparam logic [ALUOP_W-1:0] OP_SLT  = ALUOP_W'(8'h2A);
   localparam logic [ALUOP_W-1:0] OP_SLTU = ALUOP_W'(8'h2B);
   localparam logic [ALUOP_W-1:0] OP_DIV  = ALUOP_W'(8'h1A);
   localparam logic [ALUOP_W-1:0] OP_DIVU = ALUOP_W'(8'h1B);
`ifdef EX_OVERFLOW_TRAP_EN
   localparam logic [ALUOP_W-1:0] OP_ADD  = ALUOP_W'(8'h20);
   localparam logic [ALUOP_W-1:0] OP_SUB  = ALUOP_W'(8'h22);
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_rem;
   logic [DATA_W-1:0]   r_quot;
   logic [DATA_W-1:0]   r_dvs;
   logic                r_neg_q;
   logic                r_neg_r;
   logic [DATA_W-1:0]   r_hi;
   logic [DATA_W-1:0]   r_lo;

   logic [ALUOP_W-1:0]  w_op;
   logic [DATA_W-1:0]   w_a;
   logic [DATA_W-1:0]   w_b;
   logic [4:0]          w_sh;
   logic                w_is_div;
   logic                w_is_divs;
   logic                w_dvs_zero;
   logic [DATA_W-1:0]   w_abs1;
   logic [DATA_W-1:0]   w_abs2;
   logic [DATA_W-1:0]   w_sum;
   logic [DATA_W-1:0]   w_dif;
   logic [DATA_W-1:0]   w_logic;
   logic [DATA_W-1:0]   w_shift;
   logic [DATA_W-1:0]   w_arith;
   logic [DATA_W-1:0]   w_res;
   logic                w_ov;
   logic [DATA_W:0]     w_part;
   logic [DATA_W:0]     w_trial;
   logic                w_ge;
   logic [DATA_W-1:0]   w_rem_nxt;
   logic [DATA_W-1:0]   w_quot_nxt;
   logic [DATA_W-1:0]   w_hi_fix;
   logic [DATA_W-1:0]   w_lo_fix;

   assign w_op       = bus.aluop_i;
   assign w_a        = bus.reg1_i;
   assign w_b        = bus.reg2_i;
   assign w_sh       = bus.reg2_i[4:0];
   assign w_is_divs  = (w_op == OP_DIV);
   assign w_is_div   = w_is_divs || (w_op == OP_DIVU);
   assign w_dvs_zero = (w_b == '0);
   assign w_abs1     = (w_is_divs && w_a[M]) ? -w_a : w_a;
   assign w_abs2     = (w_is_divs && w_b[M]) ? -w_b : w_b;
   assign w_sum      = w_a + w_b;
   assign w_dif      = w_a - w_b;

   always_comb begin
      w_logic = '0;
      unique case (1'b1)
         (w_op == OP_AND): w_logic = w_a & w_b;
         (w_op == OP_OR):  w_logic = w_a | w_b;
         (w_op == OP_XOR): w_logic = w_a ^ w_b;
         (w_op == OP_NOR): w_logic = ~(w_a | w_b);
         default:          w_logic = '0;
      endcase
   end

   always_comb begin
      w_shift = '0;
      unique case (1'b1)
         (w_op == OP_SLL): w_shift = w_a << w_sh;
         (w_op == OP_SRL): w_shift = w_a >> w_sh;
         (w_op == OP_SRA): w_shift = $signed(w_a) >>> w_sh;
         default:          w_shift = '0;
      endcase
   end

   always_comb begin
      w_arith = '0;
      unique case (1'b1)
         (w_op == OP_ADDU): w_arith = w_sum;
         (w_op == OP_SUBU): w_arith = w_dif;
         (w_op == OP_SLT):
            w_arith = DATA_W'($signed(w_a) < $signed(w_b));
         (w_op == OP_SLTU): w_arith = DATA_W'(w_a < w_b);
`ifdef EX_OVERFLOW_TRAP_EN
         (w_op == OP_ADD):  w_arith = w_sum;
         (w_op == OP_SUB):  w_arith = w_dif;
`endif
         default:           w_arith = '0;
      endcase
   end

   always_comb begin
      w_res = '0;
      unique case (1'b1)
         (bus.alusel_i == SEL_LOGIC): w_res = w_logic;
         (bus.alusel_i == SEL_SHIFT): w_res = w_shift;
         (bus.alusel_i == SEL_ARITH): w_res = w_arith;
         default:                     w_res = '0;
      endcase
   end

`ifdef EX_OVERFLOW_TRAP_EN
   // Overflow: result sign disagrees with rs where the math says it can't.
   assign w_ov = (bus.alusel_i == SEL_ARITH) && (
      ((w_op == OP_ADD) && (w_a[M] == w_b[M]) && (w_sum[M] != w_a[M])) ||
      ((w_op == OP_SUB) && (w_a[M] != w_b[M]) && (w_dif[M] != w_a[M])));
   assign bus.ov_o = !rst && w_ov;
`else
   assign w_ov = 1'b0;
`endif

   // One restoring step: shift in next dividend bit, keep trial if >= 0.
   assign w_part     = {r_rem, r_quot[M]};
   assign w_trial    = w_part - {1'b0, r_dvs};
   assign w_ge       = !w_trial[DATA_W];
   assign w_rem_nxt  = w_ge ? w_trial[M:0] : w_part[M:0];
   assign w_quot_nxt = {r_quot[M-1:0], w_ge};
   assign w_lo_fix   = r_neg_q ? -w_quot_nxt : w_quot_nxt;
   assign w_hi_fix   = r_neg_r ? -w_rem_nxt : w_rem_nxt;

   always_comb begin
      w_state_nxt    = r_state;
      bus.stallreq_o = 1'b0;
      bus.whilo_o    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_is_div) begin
               bus.stallreq_o = 1'b1;
               w_state_nxt = w_dvs_zero ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            bus.stallreq_o = 1'b1;
            if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            bus.whilo_o = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (rst || bus.flush_i) begin
         w_state_nxt    = S_IDLE;
         bus.stallreq_o = 1'b0;
         bus.whilo_o    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_rem   <= '0;
         r_quot  <= '0;
         r_dvs   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else if (!bus.flush_i) begin
         if (r_state == S_IDLE && w_is_div) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quot  <= w_abs1;
            r_dvs   <= w_abs2;
            r_neg_q <= w_is_divs && (w_a[M] ^ w_b[M]);
            r_neg_r <= w_is_divs && w_a[M];
            if (w_dvs_zero) begin
               r_hi <= w_a;
               r_lo <= '1;
            end
         end else if (r_state == S_BUSY) begin
            r_cnt  <= r_cnt + 1'b1;
            r_rem  <= w_rem_nxt;
            r_quot <= w_quot_nxt;
            if (r_cnt == CNT_LAST) begin
               r_hi <= w_hi_fix;
               r_lo <= w_lo_fix;
            end
         end
      end
   end

   assign bus.wd_o    = rst ? '0 : bus.wd_i;
   assign bus.wreg_o  = !rst && !bus.flush_i && !w_is_div &&
                        !w_ov && bus.wreg_i;
   assign bus.wdata_o = rst ? '0 : w_res;
   assign bus.hi_o    = rst ? '0 : r_hi;
   assign bus.lo_o    = rst ? '0 : r_lo;
endmodule

// File: tb/tb_ex_alu_div.sv
// tb_ex_alu_div: scoreboard bench for ex_alu_div.
// Expected results are queued at drive time, popped at DUT output.
module tb_ex_alu_div;
   localparam logic [2:0] SEL_NOP   = 3'b000;
   localparam logic [2:0] SEL_LOGIC = 3'b001;
   localparam logic [2:0] SEL_SHIFT = 3'b010;
   localparam logic [2:0] SEL_BAD   = 3'b011;
   localparam logic [2:0] SEL_ARITH = 3'b100;

   localparam logic [7:0] OP_AND  = 8'h24;
   localparam logic [7:0] OP_NOR  = 8'h27;
   localparam logic [7:0] OP_SLL  = 8'h7C;
   localparam logic [7:0] OP_SRL  = 8'h02;
   localparam logic [7:0] OP_SRA  = 8'h03;
   localparam logic [7:0] OP_ADDU = 8'h21;
   localparam logic [7:0] OP_SUBU = 8'h23;
   localparam logic [7:0] OP_SLT  = 8'h2A;
   localparam logic [7:0] OP_SLTU = 8'h2B;
   localparam logic [7:0] OP_DIV  = 8'h1A;
   localparam logic [7:0] OP_DIVU = 8'h1B;
   localparam logic [7:0] OP_ADD  = 8'h20;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      int          n;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   ex_alu_div_if #(
      .DATA_W(32), .ALUOP_W(8), .ALUSEL_W(3), .REGADDR_W(5)
   ) bus ();

   ex_alu_div #(
      .DATA_W(32), .ALUOP_W(8), .ALUSEL_W(3), .REGADDR_W(5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic drv(input logic [2:0] sel, input logic [7:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic wr);
      bus.alusel_i = sel;
      bus.aluop_i  = op;
      bus.reg1_i   = a;
      bus.reg2_i   = b;
      bus.wd_i     = 5'd7;
      bus.wreg_i   = wr;
   endtask

   task automatic do_alu(input string tag, input logic [2:0] sel,
                         input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic wr,
                         input logic [31:0] res);
      exp_t e;
      sb_q.push_back('{res, {31'b0, wr}, 0});
      drv(sel, op, a, b, wr);
      @(negedge clk);
      e = sb_q.pop_front();
      chk({tag, "_wdata"}, bus.wdata_o, e.a);
      chk({tag, "_wreg"}, {31'b0, bus.wreg_o}, e.b);
      chk({tag, "_wd"}, {27'b0, bus.wd_o}, 32'd7);
      chk({tag, "_stall"}, {31'b0, bus.stallreq_o}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_div(input string tag, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lo, input logic [31:0] hi,
                         input int stall);
      exp_t e;
      int   cnt;
      bit   got;
      bit   wbad;
      cnt  = 0;
      got  = 0;
      wbad = 0;
      sb_q.push_back('{lo, hi, stall});
      drv(SEL_NOP, op, a, b, 1'b1);
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (bus.wreg_o) wbad = 1;
         if (bus.stallreq_o) cnt++;
         if (bus.whilo_o) begin
            e = sb_q.pop_front();
            chk({tag, "_lo"}, bus.lo_o, e.a);
            chk({tag, "_hi"}, bus.hi_o, e.b);
            chk({tag, "_stall"}, 32'(cnt), 32'(e.n));
            got = 1;
         end
         @(posedge clk);
         #1;
         if (got) break;
      end
      if (!got) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
         e = sb_q.pop_front();
      end
      chk({tag, "_wreg0"}, {31'b0, wbad}, 32'd0);
      drv(SEL_NOP, 8'h00, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      chk({tag, "_whilo1"}, {31'b0, bus.whilo_o}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int wh;
      bus.flush_i = 1'b0;
      drv(SEL_LOGIC, OP_DIV, -32'sd7, 32'd2, 1'b1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_wd", {27'b0, bus.wd_o}, 32'd0);
         chk("rst_wreg", {31'b0, bus.wreg_o}, 32'd0);
         chk("rst_wdata", bus.wdata_o, 32'd0);
         chk("rst_whilo", {31'b0, bus.whilo_o}, 32'd0);
         chk("rst_hi", bus.hi_o, 32'd0);
         chk("rst_lo", bus.lo_o, 32'd0);
         chk("rst_stall", {31'b0, bus.stallreq_o}, 32'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      do_div("div_m7_2", OP_DIV, -32'sd7, 32'd2,
             32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);

      do_alu("subu", SEL_ARITH, OP_SUBU, 32'd5, 32'd7, 1'b1,
             32'hFFFF_FFFE);
      do_alu("slt", SEL_ARITH, OP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0,
             32'd1);
      do_alu("sra", SEL_SHIFT, OP_SRA, 32'h8000_0000, 32'd4, 1'b1,
             32'hF800_0000);
      do_alu("srl", SEL_SHIFT, OP_SRL, 32'h8000_0000, 32'd4, 1'b1,
             32'h0800_0000);
      do_alu("sll", SEL_SHIFT, OP_SLL, 32'd1, 32'hFFFF_FFFF, 1'b1,
             32'h8000_0000);
      do_alu("and", SEL_LOGIC, OP_AND, 32'h0000_F0F0, 32'h0000_FF00,
             1'b1, 32'h0000_F000);
      do_alu("nor", SEL_LOGIC, OP_NOR, 32'd0, 32'd0, 1'b0,
             32'hFFFF_FFFF);
      do_alu("sltu", SEL_ARITH, OP_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b1,
             32'd0);
      do_alu("addu", SEL_ARITH, OP_ADDU, 32'hFFFF_FFFF, 32'd2, 1'b1,
             32'd1);
      do_alu("badsel", SEL_BAD, OP_AND, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             1'b1, 32'd0);
`ifdef EX_OVERFLOW_TRAP_EN
      drv(SEL_ARITH, OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1);
      @(negedge clk);
      chk("add_ov", {31'b0, bus.ov_o}, 32'd1);
      @(posedge clk);
      #1;
      do_alu("add_ov", SEL_ARITH, OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0,
             32'h8000_0000);
      drv(SEL_ARITH, OP_ADD, 32'd1, 32'd1, 1'b1);
      @(negedge clk);
      chk("add_noov", {31'b0, bus.ov_o}, 32'd0);
      @(posedge clk);
      #1;
      do_alu("add_1_1", SEL_ARITH, OP_ADD, 32'd1, 32'd1, 1'b1, 32'd2);
`else
      do_alu("add_unk", SEL_ARITH, OP_ADD, 32'd1, 32'd1, 1'b1, 32'd0);
`endif

      do_div("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h10,
             32'h0FFF_FFFF, 32'h0000_000F, 33);
      do_div("div_min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h8000_0000, 32'd0, 33);
      do_div("divu_z", OP_DIVU, 32'd9, 32'd0,
             32'hFFFF_FFFF, 32'd9, 1);

      drv(SEL_NOP, OP_DIV, 32'd1000, 32'd3, 1'b1);
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      bus.flush_i = 1'b1;
      #1;
      chk("fl_stall", {31'b0, bus.stallreq_o}, 32'd0);
      chk("fl_wreg", {31'b0, bus.wreg_o}, 32'd0);
      chk("fl_whilo", {31'b0, bus.whilo_o}, 32'd0);
      @(posedge clk);
      #1;
      bus.flush_i = 1'b0;
      drv(SEL_NOP, 8'h00, 32'd0, 32'd0, 1'b0);
      wh = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.whilo_o || bus.stallreq_o) wh++;
      end
      chk("fl_nowhilo", 32'(wh), 32'd0);
      chk("fl_lo_hold", bus.lo_o, 32'hFFFF_FFFF);
      chk("fl_hi_hold", bus.hi_o, 32'd9);
      @(posedge clk);
      #1;
      do_div("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 33);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ex_alu_div.md
Name: ex_alu_div

Overview:
Execute stage of the 5-stage MIPS32 pipeline. It consumes the decoded operation, operands and destination fields held by the ID/EX register, and produces the write-back data for the EX/MEM register. Logic, shift and add/sub/compare operations complete in a single cycle. DIV/DIVU run on an internal radix-2 restoring divider FSM, which holds the pipeline via stallreq_o until the quotient and remainder are ready.

Parameters:
DATA_W, 32, operand/result width (divider counter sized log2(DATA_W)+1)
ALUOP_W, 8, aluop field width
ALUSEL_W, 3, alusel field width
REGADDR_W, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush_i  in  1  annul current instruction; aborts the divider
aluop_i  in  ALUOP_W  operation code
alusel_i  in  ALUSEL_W  result class select
reg1_i  in  DATA_W  operand 1 (rs / dividend)
reg2_i  in  DATA_W  operand 2 (rt or immediate / divisor / shift amount in [4:0])
wd_i  in  REGADDR_W  destination register
wreg_i  in  1  destination write enable
wd_o  out  REGADDR_W  destination to EX/MEM
wreg_o  out  1  write enable to EX/MEM
wdata_o  out  DATA_W  GPR result
whilo_o  out  1  HI/LO write enable (1 for one cycle at divide completion)
hi_o  out  DATA_W  remainder
lo_o  out  DATA_W  quotient
stallreq_o  out  1  request to freeze PC, IF/ID and ID/EX

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- While rst=1, outputs are wd_o=0, wreg_o=0, wdata_o=0, whilo_o=0, hi_o=0, lo_o=0, stallreq_o=0, and the FSM is forced to IDLE.
- alusel codes: NOP=000, LOGIC=001, SHIFT=010, ARITH=100. Any other code gives wdata_o=0.
- aluop codes:
  - AND=0x24, OR=0x25, XOR=0x26, NOR=0x27.
  - SLL=0x7C, SRL=0x02, SRA=0x03. Shift amount is reg2_i[4:0]; the shifted value is reg1_i.
  - ADDU=0x21, SUBU=0x23: modulo 2^DATA_W, no flags.
  - SLT=0x2A (signed), SLTU=0x2B (unsigned): result is 1 or 0.
  - DIV=0x1A, DIVU=0x1B.
- Single-cycle operations:
  - Outputs are combinational from the inputs; latency is 0 cycles.
  - wd_o=wd_i and wreg_o=wreg_i.
  - whilo_o=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - When aluop_i is DIV/DIVU and flush_i=0, latch |reg1_i| and |reg2_i| (DIVU: raw values) plus the sign bits, clear the 6-bit counter and go to BUSY. stallreq_o=1 in this cycle.
  - A divisor of 0 goes directly to DONE with lo=all-ones and hi=reg1_i.
- BUSY:
  - Each cycle, shift the partial remainder left by one, trial-subtract the divisor, and set the quotient bit. Counter increments.
  - After 32 iterations (counter==31 at the clock edge), go to DONE. stallreq_o=1 throughout.
- DONE:
  - stallreq_o=0 and whilo_o=1.
  - Signed fixup: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0.
  - Next state is unconditionally IDLE.
- Timing: stall spans the issue cycle plus 32 BUSY cycles (33 cycles). The result is visible in cycle 33 after issue.
- hi_o and lo_o hold their last values outside DONE; whilo_o qualifies them.
- wreg_o=0 for DIV/DIVU in every state, since the result goes to HI/LO, not a GPR.
- flush_i=1 in any state:
  - Next state is IDLE.
  - stallreq_o=0 in the same cycle (combinational).
  - wreg_o=0 and whilo_o=0 in the same cycle.
  - Partial results are discarded.
- rst mid-divide: next state is IDLE and no HI/LO write occurs.

Optional Feature:
EX_OVERFLOW_TRAP_EN
- Defined:
  - Adds aluop ADD=0x20 and SUB=0x22 (signed) and an output port ov_o (1 bit).
  - On signed overflow (operands of equal sign for ADD, or differing sign for SUB, with the result sign differing from reg1_i), ov_o=1 and wreg_o=0. wdata_o still carries the wrapped sum.
  - ov_o=0 under rst.
- Undefined: no ov_o port; 0x20/0x22 decode as unknown and give wdata_o=0.

Test Plan:
- Reset held 2 cycles during a DIV issue -> all outputs 0, stallreq_o=0; after release with DIV still present, stall restarts from the issue cycle.
- ARITH SUBU 5-7; SLT 0xFFFFFFFF vs 1; SHIFT SRA 0x80000000 by 4 -> wdata_o = 0xFFFFFFFE, 1, 0xF8000000 respectively; wreg_o follows wreg_i.
- DIV -7/2 -> stallreq_o high for exactly 33 cycles; in DONE, lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF, whilo_o=1 for one cycle. DIVU 0xFFFFFFFF/0x10 -> lo_o=0x0FFFFFFF, hi_o=0xF.
- DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0. DIVU 9/0 -> stall for 1 cycle; lo_o=0xFFFFFFFF, hi_o=9.
- flush_i pulsed in BUSY cycle 10 -> stallreq_o=0 in the same cycle, no whilo_o pulse; the next DIV 100/7 gives lo_o=14, hi_o=2.
- (EX_OVERFLOW_TRAP_EN) ADD 0x7FFFFFFF+1 -> ov_o=1, wreg_o=0; ADD 1+1 -> ov_o=0, wdata_o=2.
